// File: rtl/speed_pkg.sv
// Shared definitions for the speed tick generator: speed codes, button FSM
// state encoding and the speed stepping helper.
package speed_pkg;

    typedef enum logic [1:0] {
        SPD_STOP = 2'd0,
        SPD_1    = 2'd1,
        SPD_2    = 2'd2,
        SPD_3    = 2'd3
    } spd_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } btn_state_t;

    // Speed levels cycle 0 -> 1 -> 2 -> 3 -> 0 on each accepted press
    function automatic spd_t next_spd(input spd_t cur);
        return spd_t'(cur + 2'd1);
    endfunction

endpackage

// File: rtl/speed_tick_gen_if.sv
// Control and status bundle between the speed tick generator and its user:
// run enable and raw button in, speed level and pulses out.
interface speed_tick_gen_if;

    logic       on_off;
    logic       btn_n;
    logic [1:0] spd;
    logic       act_tick;
    logic       spd_chg;

    modport master (
        output on_off,
        output btn_n,
        input  spd,
        input  act_tick,
        input  spd_chg
    );

    modport slave (
        input  on_off,
        input  btn_n,
        output spd,
        output act_tick,
        output spd_chg
    );

endinterface

// File: rtl/btn_debounce_fsm.sv
// Speed button front end: two-flop synchronizer, press/release debounce FSM
// and debounce counter. Emits a single-cycle step per accepted press.
module btn_debounce_fsm
    import speed_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic btn_n,
    output logic step
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             pressed;
    logic             cnt_done;
    btn_state_t       state_q;
    btn_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign pressed  = ~sync_q[1];
    assign cnt_done = (cnt_q == CNT_LAST);

    // Bring the asynchronous button into the clock domain; idle level is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    // State and debounce count advance only while the block is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A level must stay stable for DEB_CYCLES checks before the FSM accepts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = REL_CHK;
                    cnt_d   = '0;
                end
            end
            REL_CHK: begin
                if (pressed) begin
                    state_d = HELD;
                end else if (cnt_done) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Step fires once, on the cycle the press check completes
    always_comb begin
        step = en && (state_q == PRESS_CHK) && pressed && cnt_done;
    end

endmodule

// File: rtl/speed_tick_gen.sv
// Speed tick generator: debounced speed button steps a 2-bit speed level,
// and a prescaler emits a one-cycle action tick at the selected period.
module speed_tick_gen
    import speed_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int PER_1      = 67_108_864,
    parameter int PER_2      = 134_217_728,
    parameter int PER_3      = 268_435_456,
    parameter int CW         = 28
) (
    input  logic              clk,
    input  logic              rst_but,
    speed_tick_gen_if.slave   bus
);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic          step;
    spd_t          spd_q;
    logic          spd_chg_q;
    logic [CW-1:0] per_last;
    logic [CW-1:0] presc_q;
    logic          wrap;
    logic          tick_q;

    assign rst_n = rst_sync_q[1];

    // Reset asserts immediately but releases only on a clock edge
    always_ff @(posedge clk or negedge rst_but) begin
        if (!rst_but) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    btn_debounce_fsm #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.on_off),
        .btn_n (bus.btn_n),
        .step  (step)
    );

    // Each accepted press moves to the next speed and flags the change next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q     <= SPD_STOP;
            spd_chg_q <= 1'b0;
        end else begin
            spd_chg_q <= step;
            if (step) begin
                spd_q <= next_spd(spd_q);
            end
        end
    end

    // Terminal count of the prescaler for the current speed level
    always_comb begin
        per_last = '0;
        case (spd_q)
            SPD_1:   per_last = CW'(PER_1 - 1);
            SPD_2:   per_last = CW'(PER_2 - 1);
            SPD_3:   per_last = CW'(PER_3 - 1);
            default: per_last = '0;
        endcase
    end

    assign wrap = (presc_q == per_last);

    // Prescaler: frozen when disabled, parked at 0 when stopped, restarted on any speed change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else if (!bus.on_off) begin
            tick_q <= 1'b0;
        end else if (spd_q == SPD_STOP) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= wrap;
            presc_q <= (wrap || step) ? '0 : presc_q + CW'(1);
        end
    end

    assign bus.spd      = spd_q;
    assign bus.act_tick = tick_q;
    assign bus.spd_chg  = spd_chg_q;

endmodule
